// File: rtl/ras_pkg.sv
// Shared types and constants for the return-address stack and its checkpoint queue.
package ras_pkg;

  localparam int unsigned RAS_ADDR_W     = 32;
  localparam int unsigned RAS_DEPTH_LOG2 = 4;

  localparam logic [RAS_ADDR_W-1:0] ZERO_WORD = '0;

  // Default-width snapshot record; the top level re-declares it at its own widths.
  typedef struct packed {
    logic [RAS_DEPTH_LOG2-1:0] tp;
    logic [RAS_DEPTH_LOG2:0]   cnt;
    logic [RAS_ADDR_W-1:0]     top_val;
  } ckpt_rec_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ras_ckpt_queue.sv
// Circular checkpoint storage: alloc at tail, release at head, truncate-to-id on restore.
module ras_ckpt_queue
  import ras_pkg::*;
#(
  parameter int unsigned CKPT_LOG2 = 2,
  parameter type         rec_t     = ckpt_rec_t
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_alloc,
  input  rec_t                 i_rec,
  input  logic                 i_release,
  input  logic                 i_restore,
  input  logic [CKPT_LOG2-1:0] i_restore_id,
  output rec_t                 o_sel_rec,
  output logic [CKPT_LOG2-1:0] o_tail,
  output logic                 o_full
);

  localparam int unsigned         CKPT_NUM = 1 << CKPT_LOG2;
  localparam logic [CKPT_LOG2:0]  USED_MAX = (CKPT_LOG2 + 1)'(CKPT_NUM);

  rec_t                 r_slot [CKPT_NUM];
  logic [CKPT_LOG2-1:0] r_head, r_tail, w_head_d, w_tail_d;
  logic [CKPT_LOG2:0]   r_used, w_used_d;
  logic                 w_full, w_alloc_ok, w_rel_ok;
  logic [CKPT_LOG2-1:0] w_dist;
  logic [CKPT_LOG2:0]   w_inc, w_dec;

  assign w_full     = (r_used == USED_MAX);
  assign w_alloc_ok = i_alloc & ~i_restore & ~w_full;
  assign w_rel_ok   = i_release & (r_used != '0);
  assign w_dist     = i_restore_id - r_head;
  assign w_inc      = (CKPT_LOG2 + 1)'(w_alloc_ok);
  assign w_dec      = (CKPT_LOG2 + 1)'(w_rel_ok);

  always_comb begin
    w_head_d = r_head;
    w_tail_d = r_tail;
    w_used_d = r_used;
    if (i_restore) begin
      w_tail_d = i_restore_id;
      // Restoring the oldest slot empties the queue; head stays equal to tail so
      // that tail - head keeps tracking the occupancy.
      if (w_dist != '0) begin
        w_used_d = {1'b0, w_dist} - w_dec;
        w_head_d = r_head + CKPT_LOG2'(w_rel_ok);
      end else begin
        w_used_d = '0;
      end
    end else begin
      w_tail_d = r_tail + CKPT_LOG2'(w_alloc_ok);
      w_head_d = r_head + CKPT_LOG2'(w_rel_ok);
      w_used_d = r_used + w_inc - w_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_used <= '0;
      for (int unsigned i = 0; i < CKPT_NUM; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_head <= w_head_d;
      r_tail <= w_tail_d;
      r_used <= w_used_d;
      if (w_alloc_ok) begin
        r_slot[r_tail] <= i_rec;
      end
    end
  end

  assign o_sel_rec = r_slot[i_restore_id];
  assign o_tail    = r_tail;
  assign o_full    = w_full;

endmodule

// File: rtl/ras_ckpt.sv
// Return-address stack with checkpointed single-cycle misprediction repair.
// Optional RAS_PERF_CNT_EN adds overflow/underflow/restore event counters.
module ras_ckpt
  import ras_pkg::*;
#(
  parameter int unsigned ADDR_W     = RAS_ADDR_W,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned CKPT_LOG2  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [ADDR_W-1:0]    push_addr,
  output logic [ADDR_W-1:0]    top_addr,
  output logic                 top_valid,
  input  logic                 ckpt_alloc,
  output logic [CKPT_LOG2-1:0] ckpt_id,
  output logic                 ckpt_full,
  input  logic                 ckpt_release,
  input  logic                 restore,
  input  logic [CKPT_LOG2-1:0] restore_id
`ifdef RAS_PERF_CNT_EN
  ,
  output logic [15:0]          overflow_cnt,
  output logic [15:0]          underflow_cnt,
  output logic [15:0]          restore_cnt
`endif
);

  localparam int unsigned          DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  CNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef struct packed {
    logic [DEPTH_LOG2-1:0] tp;
    logic [DEPTH_LOG2:0]   cnt;
    logic [ADDR_W-1:0]     top_val;
  } rec_t;

  logic [ADDR_W-1:0]     r_entry [DEPTH];
  logic [DEPTH_LOG2-1:0] r_tp, w_tp_d, w_wr_idx;
  logic [DEPTH_LOG2:0]   r_cnt, w_cnt_d;
  logic                  w_wr_en;
  logic [ADDR_W-1:0]     w_wr_data;
  rec_t                  w_snap, w_sel_rec;
  logic [CKPT_LOG2-1:0]  w_tail;
  logic                  w_full;

  // Snapshot reflects the state before this cycle's push/pop.
  assign w_snap = '{tp: r_tp, cnt: r_cnt, top_val: r_entry[r_tp]};

  ras_ckpt_queue #(
    .CKPT_LOG2 (CKPT_LOG2),
    .rec_t     (rec_t)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_alloc      (ckpt_alloc),
    .i_rec        (w_snap),
    .i_release    (ckpt_release),
    .i_restore    (restore),
    .i_restore_id (restore_id),
    .o_sel_rec    (w_sel_rec),
    .o_tail       (w_tail),
    .o_full       (w_full)
  );

  always_comb begin
    w_tp_d    = r_tp;
    w_cnt_d   = r_cnt;
    w_wr_en   = 1'b0;
    w_wr_idx  = r_tp;
    w_wr_data = push_addr;
    if (restore) begin
      // Writing the saved top back undoes a pop-then-push overwrite.
      w_tp_d    = w_sel_rec.tp;
      w_cnt_d   = w_sel_rec.cnt;
      w_wr_en   = 1'b1;
      w_wr_idx  = w_sel_rec.tp;
      w_wr_data = w_sel_rec.top_val;
    end else if (push && pop) begin
      w_wr_en = 1'b1;
    end else if (push) begin
      w_tp_d   = r_tp + 1'b1;
      w_wr_en  = 1'b1;
      w_wr_idx = w_tp_d;
      if (r_cnt != CNT_MAX) begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end else if (pop && (r_cnt != '0)) begin
      w_tp_d  = r_tp - 1'b1;
      w_cnt_d = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tp  <= '0;
      r_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_entry[i] <= ADDR_W'(ZERO_WORD);
      end
    end else begin
      r_tp  <= w_tp_d;
      r_cnt <= w_cnt_d;
      if (w_wr_en) begin
        r_entry[w_wr_idx] <= w_wr_data;
      end
    end
  end

  assign top_addr  = r_entry[r_tp];
  assign top_valid = (r_cnt != '0);
  assign ckpt_id   = w_tail;
  assign ckpt_full = w_full;

`ifdef RAS_PERF_CNT_EN
  logic [15:0] r_ovf_cnt, r_unf_cnt, r_rst_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
      r_rst_cnt <= '0;
    end else begin
      if (!restore && push && !pop && (r_cnt == CNT_MAX)) begin
        r_ovf_cnt <= sat_inc16(r_ovf_cnt);
      end
      if (!restore && pop && !push && (r_cnt == '0)) begin
        r_unf_cnt <= sat_inc16(r_unf_cnt);
      end
      if (restore) begin
        r_rst_cnt <= sat_inc16(r_rst_cnt);
      end
    end
  end

  assign overflow_cnt  = r_ovf_cnt;
  assign underflow_cnt = r_unf_cnt;
  assign restore_cnt   = r_rst_cnt;
`endif

endmodule
